key_step_sel: RTL

KEY_STEP_SEL -- requirements
Module: key_step_sel

---
 rtl/key_step_sel.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/key_step_sel.sv
// rtl/key_step_sel.sv - debounced up/down key stepper for a 0..MAX_INDEX frequency index
// Optional auto-repeat on long hold is compiled in by defining KEY_AUTO_REPEAT_EN.
module key_step_sel #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter int MAX_INDEX       = 14,
  parameter int INIT_INDEX      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_up_n,
  input  logic       key_dn_n,
  output logic [3:0] key_data,
  output logic       key_chg
);

  localparam int MAXC_A = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int MAXC   = (MAXC_A > REPEAT_CYCLES) ? MAXC_A : REPEAT_CYCLES;
  localparam int CW     = (MAXC > 1) ? $clog2(MAXC + 1) : 1;

  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_AUTO_REPEAT_EN
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
`endif
  localparam logic [3:0] MAX4  = 4'(MAX_INDEX);
  localparam logic [3:0] INIT4 = 4'(INIT_INDEX);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HELD,
`ifdef KEY_AUTO_REPEAT_EN
    REPEAT,
`endif
    REL_DB
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          act_up, act_up_nxt;
  logic          step;
  logic [1:0]    up_sync, dn_sync;
  logic          up, dn, act_key;

  // Synchronizers reset to the released (high) raw level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_sync <= 2'b11;
      dn_sync <= 2'b11;
    end else begin
      up_sync <= {up_sync[0], key_up_n};
      dn_sync <= {dn_sync[0], key_dn_n};
    end
  end

  assign up      = ~up_sync[1];
  assign dn      = ~dn_sync[1];
  assign act_key = act_up ? up : dn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      act_up <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      act_up <= act_up_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    act_up_nxt = act_up;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (up ^ dn) begin
          act_up_nxt = up;
          cnt_nxt    = '0;
          state_nxt  = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (!act_key) begin
          state_nxt = IDLE;
        end else if (cnt == DB_LAST) begin
          step      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = HELD;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!act_key) begin
          cnt_nxt   = '0;
          state_nxt = REL_DB;
        end
`ifdef KEY_AUTO_REPEAT_EN
        else if (cnt == HOLD_LAST) begin
          cnt_nxt   = '0;
          state_nxt = REPEAT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
`ifdef KEY_AUTO_REPEAT_EN
      REPEAT: begin
        if (!act_key) begin
          cnt_nxt   = '0;
          state_nxt = REL_DB;
        end else if (cnt == REP_LAST) begin
          step    = 1'b1;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`endif
      REL_DB: begin
        // A re-assertion (bounce) restarts the release window
        if (act_key) begin
          cnt_nxt = '0;
        end else if (cnt == DB_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Saturating step; no pulse when already at a limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_data <= INIT4;
      key_chg  <= 1'b0;
    end else begin
      key_chg <= 1'b0;
      if (step) begin
        if (act_up && key_data < MAX4) begin
          key_data <= key_data + 4'd1;
          key_chg  <= 1'b1;
        end else if (!act_up && key_data != 4'd0) begin
          key_data <= key_data - 4'd1;
          key_chg  <= 1'b1;
        end
      end
    end
  end

endmodule
